i2s_tx: RTL and testbench
=========================

# i2s_tx

Serial audio transmitter at the output end of the loopback effect chain. It accepts one 16-bit unsigned sample per strobe from the effect chain's `Out1`/`ce_out` pair. It holds the sample in a single-entry register and serialises it as a standard Philips I2S stereo frame, sending the mono sample on both channels, to the codec DAC. It also emits a once-per-frame load strobe that upstream logic may use as its sample-rate clock enable.

## Interface
- `CLK_DIV`, default 4: clk cycles per BCLK half-period; legal range ≥1. With a 12.288 MHz clk this gives BCLK = 1.536 MHz and Fs = 48 kHz.
- `clk`  in  1  system clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `sample_in`  in  16  uint16 audio sample (offset binary, 0x8000 = silence)
- `sample_valid`  in  1  one-cycle strobe; latch `sample_in`
- `i2s_bclk`  out  1  bit clock
- `i2s_lrck`  out  1  word select; 0 = left, 1 = right
- `i2s_sdata`  out  1  serial data, MSB first
- `load_strobe`  out  1  one-cycle pulse when the hold register is transferred to the shifter
- `underrun`  out  1  one-cycle pulse, coincident with `load_strobe`, when the hold register was empty
- `overrun`  out  1  one-cycle pulse when `sample_valid` arrives while the hold register is still full

## Operation
- **Hold register:** `hold_data[15:0]` and `hold_full`.
  - `sample_valid` writes `hold_data` and sets `hold_full`.
  - If `hold_full` was already set and no load occurs in the same cycle, pulse `overrun`. The newest sample wins.
- **Divider:** `div_cnt` counts 0..CLK_DIV-1. At the terminal count, `i2s_bclk` toggles and the counter wraps. A toggle 1→0 is a falling tick.
- **Slot counter:** `slot[4:0]` increments modulo 32 on each falling tick. All of `i2s_lrck`, `i2s_sdata` and the shifter update only on falling ticks, in the same clk cycle that `i2s_bclk` goes low.
- **Frame layout** (32 slots, 1-bit I2S delay):
  - Entering slot 1: load. Set `i2s_sdata`=L[15].
  - Slots 2..15: L[14..1].
  - Entering slot 16: `i2s_lrck`→1, `i2s_sdata`=L[0].
  - Entering slot 17: R[15].
  - Slots 18..31: R[14..1].
  - Entering slot 0: `i2s_lrck`→0, `i2s_sdata`=R[0].
- **Load** (falling tick entering slot 1):
  - Shifter ← {W, W}, where W = converted `hold_data` (see Configuration).
  - Clear `hold_full` and pulse `load_strobe`.
  - If `hold_full` was 0, pulse `underrun` and re-send the stale `hold_data`.
- **Simultaneous `sample_valid` and load:**
  - The load uses the pre-edge `hold_data`/`hold_full`.
  - The new sample is written to hold, and `hold_full` ends at 1.
  - No `overrun` is raised.
- **States:** implicit, IDLE_SLOT0 (after reset, until the first falling tick) → LEFT (slots 1..15) → RIGHT (16..31) → slot 0 → LEFT. There is no other state.

## Timing
- Reset values:
  - Outputs: `i2s_bclk`=0, `i2s_lrck`=0, `i2s_sdata`=0, `load_strobe`=0, `underrun`=0, `overrun`=0.
  - Internal: `div_cnt`=0, `slot`=0, shifter=0, `hold_full`=0.
  - `hold_data` = silence: 0x8000 with the macro defined, 0x0000 without it.
- After reset release:
  - First rising BCLK at clk edge CLK_DIV.
  - First falling tick, which is also the first load, at edge 2·CLK_DIV.
- BCLK period = 2·CLK_DIV clk; frame = 64·CLK_DIV clk; `load_strobe` period = 64·CLK_DIV clk.
- Latency: a sample strobed at least one cycle before a load appears as L[15] on `i2s_sdata` in that load cycle.
- Reset mid-frame: all state is cleared immediately and asynchronously. No partial frame resumes.

## Configuration
- Macro `I2S_TX_OFFSET_BIN_EN`.
  - Defined: W = {~hold_data[15], hold_data[14:0]}, converting offset binary to two's complement. `hold_data` resets to 0x8000.
  - Undefined: W = hold_data, passed through unchanged. `hold_data` resets to 0x0000.
- In both cases the transmitted reset word is 0x0000.

## Structure
- Shared package `i2s_pkg`: `SAMPLE_W`=16, `SLOTS_PER_FRAME`=32, `FRAME_BITS`=32, and the slot constants `SLOT_LOAD`=1, `SLOT_LR`=16.
- Sub-module `i2s_clkgen`: contains the divider, `i2s_bclk`, the slot counter and the falling-tick strobe. Shift, hold and flag logic stay in `i2s_tx`.

## Test plan
- Reset, CLK_DIV=2, no samples: BCLK period 4 clk. First `load_strobe` at clk edge 4 with `underrun`=1. `i2s_sdata` is constantly 0 (macro defined). `load_strobe` then repeats every 128 clk.
- `sample_in`=0xC001, strobed 10 clk before a load, macro defined: both channels carry 0x4001 MSB-first with the 1-bit delay. `i2s_lrck` toggles at slots 16 and 0. `underrun`=0.
- Same sample, macro undefined: both channels carry 0xC001.
- Two strobes between loads (0x1234, then 0x5678): `overrun` pulses on the second. The frame carries 0x5678 (undefined macro).
- `sample_valid` exactly on the load cycle with `hold_full`=0: `underrun`=1, the stale word is sent, and the new sample is sent in the next frame. No `overrun`.
- Assert `reset_n` low at slot 20: all outputs go to 0 within the same cycle. After release, timing restarts exactly as in the first scenario.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants, frame-phase states and sample conversion for the I2S transmitter.
// Macro I2S_TX_OFFSET_BIN_EN selects offset-binary to two's-complement conversion.
package i2s_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int SLOTS_PER_FRAME = 32;
  localparam int FRAME_BITS      = 32;

  localparam logic [4:0] SLOT_LOAD = 5'd1;
  localparam logic [4:0] SLOT_LR   = 5'd16;

  typedef enum logic [1:0] {
    IDLE_SLOT0 = 2'd0,
    LEFT       = 2'd1,
    RIGHT      = 2'd2,
    SLOT0      = 2'd3
  } tx_state_t;

`ifdef I2S_TX_OFFSET_BIN_EN
  localparam logic [SAMPLE_W-1:0] HOLD_RESET = 16'h8000;

  function automatic logic [SAMPLE_W-1:0] to_wire_word(input logic [SAMPLE_W-1:0] d);
    return {~d[SAMPLE_W-1], d[SAMPLE_W-2:0]};
  endfunction
`else
  localparam logic [SAMPLE_W-1:0] HOLD_RESET = 16'h0000;

  function automatic logic [SAMPLE_W-1:0] to_wire_word(input logic [SAMPLE_W-1:0] d);
    return d;
  endfunction
`endif

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock divider and frame slot counter; fall_tick marks the cycle BCLK goes low.
module i2s_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       bclk,
  output logic [4:0] slot,
  output logic       fall_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          div_tc;

  assign div_tc    = (div_cnt == DW'(CLK_DIV - 1));
  assign fall_tick = div_tc & bclk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      slot    <= '0;
    end else begin
      if (div_tc) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall_tick) slot <= slot + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Mono-to-stereo Philips I2S transmitter with a single-entry sample hold register.
// Macro I2S_TX_OFFSET_BIN_EN converts offset-binary samples to two's complement.
//
// state      | meaning
// IDLE_SLOT0 | after reset, waiting for the first falling tick
// LEFT       | slots 1..15, left word on the wire (load on entry)
// RIGHT      | slots 16..31, lrck high
// SLOT0      | slot 0, last right bit; next tick loads
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_sdata,
  output logic                load_strobe,
  output logic                underrun,
  output logic                overrun
);

  logic                  fall_tick;
  logic [4:0]            slot;
  tx_state_t             state, state_nxt;
  logic                  load;
  logic [SAMPLE_W-1:0]   hold_data;
  logic                  hold_full;
  logic [FRAME_BITS-1:0] shifter;
  logic [SAMPLE_W-1:0]   wire_word;

  i2s_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .bclk      (i2s_bclk),
    .slot      (slot),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE_SLOT0;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (fall_tick) begin
      case (state)
        IDLE_SLOT0, SLOT0: begin
          state_nxt = LEFT;
          load      = 1'b1;
        end
        LEFT:    if (slot == SLOT_LR - 5'd1) state_nxt = RIGHT;
        RIGHT:   if (slot == 5'(SLOTS_PER_FRAME - 1)) state_nxt = SLOT0;
        default: state_nxt = IDLE_SLOT0;
      endcase
    end
  end

  assign wire_word = to_wire_word(hold_data);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i2s_lrck    <= 1'b0;
      i2s_sdata   <= 1'b0;
      load_strobe <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      shifter     <= '0;
      hold_data   <= HOLD_RESET;
      hold_full   <= 1'b0;
    end else begin
      i2s_lrck    <= (state_nxt == RIGHT);
      load_strobe <= load;
      underrun    <= load & ~hold_full;
      overrun     <= sample_valid & hold_full & ~load;
      // The shifter keeps only the 31 bits still to go after L[15] leaves on the load tick.
      if (load) begin
        i2s_sdata <= wire_word[SAMPLE_W-1];
        shifter   <= {wire_word[SAMPLE_W-2:0], wire_word, 1'b0};
      end else if (fall_tick) begin
        i2s_sdata <= shifter[FRAME_BITS-1];
        shifter   <= {shifter[FRAME_BITS-2:0], 1'b0};
      end
      if (sample_valid) begin
        hold_data <= sample_in;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Randomised bench for i2s_tx, checking every cycle against a frame-level reference model.
module tb_i2s_tx;

  localparam int CD      = 2;
  localparam int FRAME   = 64 * CD;
  localparam int LOAD_PH = 2 * CD;

`ifdef I2S_TX_OFFSET_BIN_EN
  localparam logic [15:0] RST_HOLD = 16'h8000;
  function automatic logic [15:0] conv(input logic [15:0] d);
    return d ^ 16'h8000;
  endfunction
`else
  localparam logic [15:0] RST_HOLD = 16'h0000;
  function automatic logic [15:0] conv(input logic [15:0] d);
    return d;
  endfunction
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        i2s_bclk, i2s_lrck, i2s_sdata, load_strobe, underrun, overrun;

  i2s_tx #(.CLK_DIV(CD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .load_strobe  (load_strobe),
    .underrun     (underrun),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_edge;
  logic [15:0] m_hold;
  logic        m_full;
  logic [31:0] m_frame;
  logic        e_ls, e_ur, e_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, n_edge);
  endtask

  task automatic model_reset();
    n_edge  = 0;
    m_hold  = RST_HOLD;
    m_full  = 1'b0;
    m_frame = '0;
    e_ls    = 1'b0;
    e_ur    = 1'b0;
    e_ov    = 1'b0;
  endtask

  // One frame per 32 falling ticks; tick t enters slot t mod 32, and slot 1 is the load.
  task automatic model_edge(input logic sv, input logic [15:0] d);
    logic load, pre;
    n_edge++;
    load = (n_edge % (2 * CD) == 0) && ((n_edge / (2 * CD)) % 32 == 1);
    pre  = m_full;
    e_ls = load;
    e_ur = load && !pre;
    e_ov = sv && pre && !load;
    if (load) begin
      m_frame = {conv(m_hold), conv(m_hold)};
      m_full  = 1'b0;
    end
    if (sv) begin
      m_hold = d;
      m_full = 1'b1;
    end
  endtask

  task automatic check_outputs();
    int s, k;
    logic e_lr, e_sd, e_bclk;
    e_bclk = ((n_edge / CD) % 2) == 1;
    if (n_edge < 2 * CD) begin
      e_lr = 1'b0;
      e_sd = 1'b0;
    end else begin
      s    = (n_edge / (2 * CD)) % 32;
      k    = (s + 31) % 32;
      e_sd = m_frame[31 - k];
      e_lr = (s >= 16);
    end
    chk("bclk", i2s_bclk, e_bclk);
    chk("lrck", i2s_lrck, e_lr);
    chk("sdata", i2s_sdata, e_sd);
    chk("load_strobe", load_strobe, e_ls);
    chk("underrun", underrun, e_ur);
    chk("overrun", overrun, e_ov);
  endtask

  task automatic cycle(input logic sv, input logic [15:0] d);
    sample_valid = sv;
    sample_in    = d;
    @(posedge clk);
    model_edge(sv, d);
    @(negedge clk);
    sample_valid = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 16'h0);
  endtask

  task automatic run_until(input int ph);
    for (int i = 0; i < FRAME && ((n_edge + 1) % FRAME) != ph; i++) cycle(1'b0, 16'h0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;

    // idle frames: underrun every load, reset word on the wire
    idle(3 * FRAME);

    // one sample ten cycles ahead of a load
    run_until((LOAD_PH - 10 + FRAME) % FRAME);
    cycle(1'b1, 16'hC001);
    idle(2 * FRAME);

    // two strobes in one frame: overrun, newest wins
    run_until(20);
    cycle(1'b1, 16'h1234);
    idle(7);
    cycle(1'b1, 16'h5678);
    idle(2 * FRAME);

    // strobe on the load cycle with an empty hold register
    run_until(LOAD_PH);
    cycle(1'b1, 16'hABCD);
    idle(2 * FRAME);

    // random sparse sample traffic
    for (int i = 0; i < 8 * FRAME; i++)
      cycle($urandom_range(0, 39) == 0, 16'($urandom));

    // asynchronous reset in slot 20
    run_until(20 * 2 * CD);
    cycle(1'b0, 16'h0);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_bclk", i2s_bclk, 1'b0);
    chk("rst_async_lrck", i2s_lrck, 1'b0);
    chk("rst_async_sdata", i2s_sdata, 1'b0);
    chk("rst_async_load", load_strobe, 1'b0);
    chk("rst_async_underrun", underrun, 1'b0);
    chk("rst_async_overrun", overrun, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
    idle(2 * FRAME + 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
